dmem_responder: RTL

Data-memory responder for the RVI32 core's DMEM port: it answers the core's daddr/ddata_w/d_rw accesses with ddata_r. It holds a word-addressed data RAM plus a small memory-mapped register window containing a free-running timer, a compare register and a sticky status register. It sits beside the core at SoC top level, opposite the core's data-port outputs.

---
 rtl/dmem_responder.sv | 112 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM plus an MMIO register window
// (MTIME, MTIMECMP, STATUS, SCRATCH) answering the core's DMEM port.
//
// Optional timer: define DMEM_MMIO_TIMER_EN to build MTIME/MTIMECMP and
// the timer-match bit STATUS[0]; otherwise those read 0 and ignore writes.
//
// Ports:
//   CLK        clock, rising edge
//   RESET_N    asynchronous active-low reset
//   daddr      byte address from the core
//   ddata_w    store data
//   d_rw       1 = write this cycle, 0 = read
//   ddata_r    combinational read data for daddr
//   timer_irq  STATUS[0]
//   mem_err    STATUS[1] | STATUS[2]
module dmem_responder #(
    parameter int          DEPTH    = 1024,
    parameter logic [3:0]  MMIO_TAG = 4'hF
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] daddr,
    input  logic [31:0] ddata_w,
    input  logic        d_rw,
    output logic [31:0] ddata_r,
    output logic        timer_irq,
    output logic        mem_err
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] widx;
    logic          ram_hit, mmio_hit, aligned, wr;
    logic [1:0]    sel;
    logic [2:0]    status_q, status_d;
    logic [31:0]   scratch_q, scratch_d;
    logic [31:0]   mtime_rd, mtimecmp_rd;
    logic          match;

    assign widx     = daddr[AW+1:2];
    assign sel      = daddr[3:2];
    assign ram_hit  = (daddr[31:28] != MMIO_TAG) && (daddr[31:AW+2] == '0);
    assign mmio_hit = (daddr[31:28] == MMIO_TAG) && (daddr[27:4] == '0);
    assign aligned  = (daddr[1:0] == 2'b00);
    assign wr       = d_rw && aligned;

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;

    // Match compares the pre-update values, so same-cycle writes never affect it.
    assign match       = (mtime_q == mtimecmp_q);
    assign mtime_rd    = mtime_q;
    assign mtimecmp_rd = mtimecmp_q;

    always_comb begin
        mtime_d    = (wr && mmio_hit && sel == 2'd0) ? ddata_w : mtime_q + 32'd1;
        mtimecmp_d = (wr && mmio_hit && sel == 2'd1) ? ddata_w : mtimecmp_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end
`else
    assign match       = 1'b0;
    assign mtime_rd    = '0;
    assign mtimecmp_rd = '0;
`endif

    // Sets are applied after the W1C clear so they win in the same cycle.
    always_comb begin
        status_d  = (wr && mmio_hit && sel == 2'd2) ? status_q & ~ddata_w[2:0] : status_q;
        scratch_d = (wr && mmio_hit && sel == 2'd3) ? ddata_w : scratch_q;
        if (match)
            status_d[0] = 1'b1;
        if (d_rw && !aligned)
            status_d[1] = 1'b1;
        if (wr && !ram_hit && !mmio_hit)
            status_d[2] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            status_q  <= '0;
            scratch_q <= '0;
        end else begin
            status_q  <= status_d;
            scratch_q <= scratch_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr && ram_hit)
            mem[widx] <= ddata_w;
    end

    always_comb begin
        ddata_r = ram_hit  ? mem[widx] :
                  !mmio_hit ? 32'h0 :
                  sel == 2'd0 ? mtime_rd :
                  sel == 2'd1 ? mtimecmp_rd :
                  sel == 2'd2 ? {29'h0, status_q} : scratch_q;
    end

    assign timer_irq = status_q[0];
    assign mem_err   = status_q[1] | status_q[2];
endmodule
